// File: rtl/sha256_pkg.sv
// Shared types and memory-port widths for the SHA-256 engines and the memory arbiter.
package sha256_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;

endpackage

// File: rtl/sha256_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping around.
module sha256_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    logic [PTR_W:0] cand;

    // Walk the ring from the farthest slot back to ptr so the nearest hit is kept last.
    always_comb begin
        onehot = '0;
        idx    = '0;
        cand   = '0;
        any    = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ))
                cand = cand - (PTR_W+1)'(NUM_REQ);
            if (req[cand[PTR_W-1:0]])
                idx = cand[PTR_W-1:0];
        end
        if (any)
            onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/sha256_mem_arbiter.sv
// Round-robin memory-port arbiter with burst lock and forced release for SHA-256 engines.
module sha256_mem_arbiter
    import sha256_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int MAX_BURST = 20
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic                        mem_clk,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_write_data,
    input  logic [DATA_W-1:0]           mem_read_data
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(NUM_REQ - 1);

    arb_state_t          state, state_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt, acc, pick_oh;
    logic [PTR_W-1:0]    ptr, ptr_nxt, own, own_nxt, pick_idx;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                pick_any, others;

    assign acc     = gnt & req;
    assign others  = |(req & ~gnt);
    assign busy    = (state == OWN);
    assign rdata   = mem_read_data;
    assign mem_clk = clk;

    sha256_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Next-state: grant from IDLE, hold/count/release in OWN. Handoffs always pass through IDLE.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        own_nxt   = own;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = OWN;
                    gnt_nxt   = pick_oh;
                    own_nxt   = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            OWN: begin
                // req[own] high implies an access this cycle, since gnt[own] is set.
                if (!req[own] || (cnt == CNT_MAX && others)) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = (own == LAST) ? '0 : own + 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Arbiter state and read-return tracking; reset drops any read still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            gnt    <= '0;
            rvalid <= '0;
            ptr    <= '0;
            own    <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rvalid <= acc & ~req_we;
            ptr    <= ptr_nxt;
            own    <= own_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // AND-OR mux onto the memory port; all zero when nobody is accessing.
    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mem_we         = mem_we | (acc[i] & req_we[i]);
            mem_addr       = mem_addr | ({ADDR_W{acc[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
            mem_write_data = mem_write_data | ({DATA_W{acc[i]}} & req_wdata[i*DATA_W +: DATA_W]);
        end
    end

endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// Directed bench for sha256_mem_arbiter: simple engines plus a behavioural memory.
module tb_sha256_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req = '0, req_we = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      gnt, rvalid;
    logic [DW-1:0]     rdata, mem_write_data;
    logic [DW-1:0]     mem_read_data = '0;
    logic [AW-1:0]     mem_addr;
    logic              busy, mem_clk, mem_we;

    sha256_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(20)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .busy           (busy),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Background contents for words never written: 5 holds DEADBEEF, others C0DE_<addr>.
    function automatic logic [31:0] rpat(input logic [15:0] a);
        return (a == 16'h0005) ? 32'hDEADBEEF : {16'hC0DE, a};
    endfunction

    // Memory: synchronous write, registered read (data one cycle after the address).
    logic [31:0] mem [512];
    bit          wr_flag [512];
    always @(posedge mem_clk) begin
        if (mem_we) begin
            mem[mem_addr[8:0]]     <= mem_write_data;
            wr_flag[mem_addr[8:0]] <= 1'b1;
        end
        mem_read_data <= wr_flag[mem_addr[8:0]] ? mem[mem_addr[8:0]] : rpat(mem_addr);
    end

    // Engine model state: words remaining, next address, write mode.
    int          rem [N];
    logic [15:0] addr [N];
    logic [N-1:0] wr = '0;

    int checks = 0, errors = 0;
    int cyc_no = 0, n_we = 0, n_rv = 0, n_acc = 0;
    logic [N-1:0] gl [64];
    logic [N-1:0] al [64];
    logic [N-1:0] exp_rv = '0;
    logic [15:0]  exp_ra = '0;
    logic [N-1:0] s_gnt, s_rv;
    logic [31:0]  s_rdata;
    logic [15:0]  s_addr;
    logic         s_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]                = (rem[i] > 0);
            req_we[i]             = wr[i];
            req_addr[i*AW +: AW]  = addr[i];
            req_wdata[i*DW +: DW] = {16'h5A5A, addr[i]};
        end
    endtask

    task automatic start_test();
        cyc_no = 0; n_we = 0; n_rv = 0; n_acc = 0;
    endtask

    // One clock: sample mid-cycle, check the port, then advance engines after the edge.
    task automatic cyc();
        logic [N-1:0] a;
        @(negedge clk);
        s_gnt = gnt; s_rv = rvalid; s_rdata = rdata; s_addr = mem_addr; s_busy = busy;
        a = gnt & req;
        chk("rvalid", 32'(rvalid), 32'(exp_rv));
        if (exp_rv != '0) chk("rdata", rdata, rpat(exp_ra));
        if (a == '0) begin
            chk("idle_we", 32'(mem_we), 32'h0);
            chk("idle_addr", 32'(mem_addr), 32'h0);
        end else begin
            for (int i = 0; i < N; i++) if (a[i]) begin
                chk("acc_addr", 32'(mem_addr), 32'(addr[i]));
                chk("acc_we", 32'(mem_we), 32'(wr[i]));
                if (wr[i]) chk("acc_wdata", mem_write_data, {16'h5A5A, addr[i]});
            end
        end
        if (cyc_no < 64) begin gl[cyc_no] = gnt; al[cyc_no] = a; end
        cyc_no++;
        if (mem_we) n_we++;
        if (rvalid != '0) n_rv++;
        n_acc += $countones(a);
        exp_rv = a & ~wr;
        for (int i = 0; i < N; i++) if (a[i]) exp_ra = addr[i];
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) if (a[i]) begin addr[i]++; rem[i]--; end
        drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin rem[i] = 0; addr[i] = '0; end
        wr = '0;
        drive();
        exp_rv = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_write_data, 32'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        int g;
        // 1: single read of word 5
        do_reset(); start_test();
        rem[0] = 1; addr[0] = 16'h0005; drive();
        cyc(); chk("t1_gnt_c0", 32'(s_gnt), 32'h0);
        cyc(); chk("t1_gnt_c1", 32'(s_gnt), 32'h1);
               chk("t1_addr_c1", 32'(s_addr), 32'h5);
               chk("t1_busy_c1", 32'(s_busy), 32'h1);
        cyc(); chk("t1_rvalid_c2", 32'(s_rv), 32'h1);
               chk("t1_rdata_c2", s_rdata, 32'hDEADBEEF);
        cyc(); chk("t1_gnt_c3", 32'(s_gnt), 32'h0);

        // 2: four engines, three reads each, round-robin from ptr 0
        do_reset(); start_test();
        for (int i = 0; i < N; i++) begin rem[i] = 3; addr[i] = 16'(16 * i + 16); end
        drive();
        run(21);
        chk("t2_c1", 32'(gl[1]), 32'h1);   chk("t2_c5", 32'(gl[5]), 32'h0);
        chk("t2_c6", 32'(gl[6]), 32'h2);   chk("t2_c10", 32'(gl[10]), 32'h0);
        chk("t2_c11", 32'(gl[11]), 32'h4); chk("t2_c15", 32'(gl[15]), 32'h0);
        chk("t2_c16", 32'(gl[16]), 32'h8); chk("t2_acc_c18", 32'(al[18]), 32'h8);
        chk("t2_c20", 32'(gl[20]), 32'h0); chk("t2_nacc", 32'(n_acc), 32'd12);

        // 3: forced release after 20 accesses when engine 1 waits
        do_reset(); start_test();
        rem[0] = 25; addr[0] = 16'h0020; drive();
        run(5);
        rem[1] = 4; addr[1] = 16'h0040; drive();
        run(30);
        chk("t3_acc_c20", 32'(al[20]), 32'h1); chk("t3_c21", 32'(gl[21]), 32'h0);
        chk("t3_c22", 32'(gl[22]), 32'h2);     chk("t3_acc_c26", 32'(al[26]), 32'h0);
        chk("t3_c27", 32'(gl[27]), 32'h0);     chk("t3_c28", 32'(gl[28]), 32'h1);
        chk("t3_acc_c32", 32'(al[32]), 32'h1); chk("t3_c34", 32'(gl[34]), 32'h0);
        chk("t3_e0_end", 32'(addr[0]), 32'h39); chk("t3_nacc", 32'(n_acc), 32'd29);

        // 4: lone 40-word burst never loses the port
        do_reset(); start_test();
        rem[2] = 40; addr[2] = 16'h0080; drive();
        run(43);
        g = 0;
        for (int k = 1; k <= 41; k++) if (gl[k] == 4'b0100) g++;
        chk("t4_gnt_cont", 32'(g), 32'd41);
        chk("t4_nacc", 32'(n_acc), 32'd40);
        chk("t4_c42", 32'(gl[42]), 32'h0);

        // 5: engine 1 writes eight hash words at 0x100
        do_reset(); start_test();
        rem[1] = 8; addr[1] = 16'h0100; wr = 4'b0010; drive();
        run(11);
        chk("t5_nwe", 32'(n_we), 32'd8);
        chk("t5_nrv", 32'(n_rv), 32'd0);
        chk("t5_mem100", mem[9'h100], 32'h5A5A0100);
        chk("t5_mem107", mem[9'h107], 32'h5A5A0107);
        chk("t5_nowr108", 32'(wr_flag[9'h108]), 32'h0);

        // 6: reset during an engine-3 read burst
        do_reset(); start_test();
        rem[3] = 10; addr[3] = 16'h0060; drive();
        run(4);
        chk("t6_pre_gnt", 32'(gnt), 32'h8);
        chk("t6_pre_rvalid", 32'(rvalid), 32'h8);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_rvalid", 32'(rvalid), 32'h0);
        chk("t6_rst_we", 32'(mem_we), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        for (int i = 0; i < N; i++) rem[i] = 0;
        rem[1] = 2; addr[1] = 16'h0040;
        rem[3] = 2; addr[3] = 16'h0060;
        exp_rv = '0;
        drive();
        reset_n = 1'b1;
        start_test();
        run(9);
        chk("t6_c0", 32'(gl[0]), 32'h0);
        chk("t6_c1", 32'(gl[1]), 32'h2);
        chk("t6_c4", 32'(gl[4]), 32'h0);
        chk("t6_c5", 32'(gl[5]), 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
